// File: rtl/mul_div_pkg.sv
// Shared types, sizing constants and sign helpers for the multiply/divide unit.
package mul_div_pkg;

  localparam int WIDTH         = 16;
  localparam int ITER          = 16;
  localparam int MUL_START_BIT = 24;
  localparam int DIV_START_BIT = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 16'd1) : v;
  endfunction

  // 0x8000 maps to itself, which the unsigned divider treats as 32768.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return cond_neg(v, v[WIDTH-1]);
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the shared datapath: Booth add/sub + arithmetic shift, or
// restoring subtract + left shift. Divide path present only with MUL_DIV_UNIT_DIV_EN.
module mul_div_step
  import mul_div_pkg::*;
(
  input  logic             op_div,
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_1_nxt
);

  logic [WIDTH:0] booth_sum_s;

  // Booth recoding of the multiplier pair {q[0], q_1}
  always_comb begin
    case ({q[0], q_1})
      2'b01:   booth_sum_s = a + m;
      2'b10:   booth_sum_s = a - m;
      default: booth_sum_s = a;
    endcase
  end

`ifdef MUL_DIV_UNIT_DIV_EN
  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] trial_s;

  assign rem_sh_s = {a[WIDTH-1:0], q[WIDTH-1]};
  assign trial_s  = rem_sh_s - m;

  // Select multiply or divide iteration
  always_comb begin
    a_nxt   = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
    q_nxt   = {booth_sum_s[0], q[WIDTH-1:1]};
    q_1_nxt = q[0];
    if (op_div) begin
      q_1_nxt = 1'b0;
      if (!trial_s[WIDTH]) begin
        a_nxt = trial_s;
        q_nxt = {q[WIDTH-2:0], 1'b1};
      end else begin
        a_nxt = rem_sh_s;
        q_nxt = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      a_nxt   = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
      q_nxt   = {booth_sum_s[0], q[WIDTH-1:1]};
      q_1_nxt = q[0];
    end
  end
`else
  logic unused_op_s;

  assign unused_op_s = op_div;
  assign a_nxt       = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
  assign q_nxt       = {booth_sum_s[0], q[WIDTH-1:1]};
  assign q_1_nxt     = q[0];
`endif

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed 16x16 multiplier / 16/16 divider, one step per cycle.
// Divide support is built only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_unit
  import mul_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      control_signal,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] br_in,
  output logic [WIDTH-1:0] mr_out,
  output logic [WIDTH-1:0] acc_out,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_e           state_r, state_nxt_s;
  logic [4:0]       cnt_r;
  logic [WIDTH:0]   a_r, m_r, m_init_s;
  logic [WIDTH-1:0] q_r, q_init_s;
  logic             q1_r;
  logic [WIDTH:0]   step_a_s;
  logic [WIDTH-1:0] step_q_s;
  logic             step_q1_s;
  logic             mul_start_s, div_start_s, div_zero_s, op_div_s;
  logic             start_acc_s, div_zero_acc_s, last_iter_s;
  logic             busy_nxt_s, done_nxt_s;
  logic [WIDTH-1:0] res_hi_s, res_lo_s;
  logic             unused_ctrl_s;

  assign mul_start_s    = control_signal[MUL_START_BIT];
  assign start_acc_s    = (state_r == IDLE) && (mul_start_s || div_start_s);
  assign div_zero_acc_s = (state_r == IDLE) && div_zero_s;
  assign last_iter_s    = (state_r == RUN) && (cnt_r == 5'(ITER - 1));

`ifdef MUL_DIV_UNIT_DIV_EN
  logic op_div_r, neg_q_r, neg_r_r;

  // MUL wins when both start bits are set
  assign div_start_s   = control_signal[DIV_START_BIT] & ~mul_start_s;
  assign div_zero_s    = div_start_s & (br_in == 16'h0000);
  assign op_div_s      = op_div_r;
  assign unused_ctrl_s = ^{control_signal[31:26], control_signal[23:0]};

  // Operation kind and result signs captured at start
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
    end else if (start_acc_s) begin
      op_div_r <= div_start_s;
      neg_q_r  <= acc_in[WIDTH-1] ^ br_in[WIDTH-1];
      neg_r_r  <= acc_in[WIDTH-1];
    end else begin
      op_div_r <= op_div_r;
      neg_q_r  <= neg_q_r;
      neg_r_r  <= neg_r_r;
    end
  end
`else
  assign div_start_s   = 1'b0;
  assign div_zero_s    = 1'b0;
  assign op_div_s      = 1'b0;
  assign unused_ctrl_s = ^{control_signal[31:25], control_signal[23:0]};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a zero divisor goes straight to DONE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (mul_start_s) begin
          state_nxt_s = RUN;
        end else if (div_zero_s) begin
          state_nxt_s = DONE;
        end else if (div_start_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 5'(ITER - 1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Status outputs are registered copies of the upcoming state
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      RUN:     busy_nxt_s = 1'b1;
      DONE:    done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Operand preload: Booth takes raw operands, divide takes magnitudes
  always_comb begin
    q_init_s = br_in;
    m_init_s = {acc_in[WIDTH-1], acc_in};
`ifdef MUL_DIV_UNIT_DIV_EN
    if (div_start_s) begin
      q_init_s = magnitude(acc_in);
      m_init_s = {1'b0, magnitude(br_in)};
    end else begin
      q_init_s = br_in;
      m_init_s = {acc_in[WIDTH-1], acc_in};
    end
`endif
  end

  mul_div_step u_step (
    .op_div  (op_div_s),
    .a       (a_r),
    .q       (q_r),
    .q_1     (q1_r),
    .m       (m_r),
    .a_nxt   (step_a_s),
    .q_nxt   (step_q_s),
    .q_1_nxt (step_q1_s)
  );

  // Working registers and iteration counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_r   <= 17'd0;
      q_r   <= 16'h0000;
      q1_r  <= 1'b0;
      m_r   <= 17'd0;
      cnt_r <= 5'd0;
    end else if (start_acc_s) begin
      a_r   <= 17'd0;
      q_r   <= q_init_s;
      q1_r  <= 1'b0;
      m_r   <= m_init_s;
      cnt_r <= 5'd0;
    end else if (state_r == RUN) begin
      a_r   <= step_a_s;
      q_r   <= step_q_s;
      q1_r  <= step_q1_s;
      m_r   <= m_r;
      cnt_r <= last_iter_s ? 5'd0 : cnt_r + 5'd1;
    end else begin
      a_r   <= a_r;
      q_r   <= q_r;
      q1_r  <= q1_r;
      m_r   <= m_r;
      cnt_r <= 5'd0;
    end
  end

  // Final result taken from the last step's outputs so it lands with done
  always_comb begin
    res_hi_s = step_a_s[WIDTH-1:0];
    res_lo_s = step_q_s;
`ifdef MUL_DIV_UNIT_DIV_EN
    if (op_div_r) begin
      res_hi_s = cond_neg(step_a_s[WIDTH-1:0], neg_r_r);
      res_lo_s = cond_neg(step_q_s, neg_q_r);
    end else begin
      res_hi_s = step_a_s[WIDTH-1:0];
      res_lo_s = step_q_s;
    end
`endif
  end

  // Registered outputs, held until the next completion
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      mr_out      <= 16'h0000;
      acc_out     <= 16'h0000;
      div_by_zero <= 1'b0;
    end else begin
      busy <= busy_nxt_s;
      done <= done_nxt_s;
      if (last_iter_s) begin
        mr_out  <= res_hi_s;
        acc_out <= res_lo_s;
      end else if (div_zero_acc_s) begin
        mr_out  <= acc_in;
        acc_out <= 16'hFFFF;
      end else begin
        mr_out  <= mr_out;
        acc_out <= acc_out;
      end
      if (start_acc_s) begin
        div_by_zero <= div_zero_acc_s;
      end else begin
        div_by_zero <= div_by_zero;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; divide tests follow MUL_DIV_UNIT_DIV_EN.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] control_signal;
  logic [15:0] acc_in, br_in;
  logic [15:0] mr_out, acc_out;
  logic        busy, done, div_by_zero;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] MUL_GO = 32'h0100_0000;
  localparam logic [31:0] DIV_GO = 32'h0200_0000;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk            (clk),
    .rst            (rst),
    .control_signal (control_signal),
    .acc_in         (acc_in),
    .br_in          (br_in),
    .mr_out         (mr_out),
    .acc_out        (acc_out),
    .busy           (busy),
    .done           (done),
    .div_by_zero    (div_by_zero)
  );

  // Start in cycle 0, scramble operands afterwards, return at the done cycle.
  task automatic do_op(input logic [31:0] ctrl, input logic [15:0] a, input logic [15:0] b,
                       output int done_cyc, output int busy_cnt);
    @(negedge clk);
    control_signal = ctrl; acc_in = a; br_in = b;
    done_cyc = 0; busy_cnt = 0;
    for (int k = 1; k <= 40 && done_cyc == 0; k++) begin
      @(negedge clk);
      control_signal = 32'h0; acc_in = 16'hA5A5; br_in = 16'h5A5A;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cyc = k;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; control_signal = MUL_GO; acc_in = 16'h0003; br_in = 16'h0005;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if ({mr_out, acc_out} !== 32'h0) begin errors++; $display("FAIL reset_outputs: got %h want 00000000", {mr_out, acc_out}); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    control_signal = 32'h0; rst = 1'b1;
  endtask

  task automatic test_mul();
    logic [15:0] ta [4];
    logic [15:0] tb_ [4];
    logic [31:0] tp [4];
    int dc, bc;
    ta  = '{16'h0003, 16'hFFFE, 16'h7FFF, 16'h8000};
    tb_ = '{16'h0005, 16'h0003, 16'h7FFF, 16'h8000};
    tp  = '{32'h0000_000F, 32'hFFFF_FFFA, 32'h3FFF_0001, 32'h4000_0000};
    for (int i = 0; i < 4; i++) begin
      do_op(MUL_GO, ta[i], tb_[i], dc, bc);
      checks++; if (dc != 17) begin errors++; $display("FAIL mul%0d_done_cycle: got %0d want 17", i, dc); end
      checks++; if (bc != 16) begin errors++; $display("FAIL mul%0d_busy_cycles: got %0d want 16", i, bc); end
      checks++; if ({mr_out, acc_out} !== tp[i]) begin errors++; $display("FAIL mul%0d_product: got %h want %h", i, {mr_out, acc_out}, tp[i]); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL mul%0d_dbz: got %b want 0", i, div_by_zero); end
    end
  endtask

  task automatic test_back_to_back();
    int dc = 0;
    @(negedge clk);
    control_signal = MUL_GO; acc_in = 16'h0003; br_in = 16'h0005;
    for (int k = 1; k <= 40 && dc == 0; k++) begin
      @(negedge clk);
      if (done === 1'b1) dc = k;
      control_signal = (k == 5 || k == 10 || dc != 0) ? (MUL_GO | DIV_GO) : 32'h0;
      acc_in = 16'h7777; br_in = 16'h0000;
    end
    checks++; if (dc != 17) begin errors++; $display("FAIL ignore_done_cycle: got %0d want 17", dc); end
    checks++; if ({mr_out, acc_out} !== 32'h0000_000F) begin errors++; $display("FAIL ignore_product: got %h want 0000000f", {mr_out, acc_out}); end
    @(negedge clk);
    control_signal = 32'h0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", done); end
    checks++; if ({mr_out, acc_out} !== 32'h0000_000F) begin errors++; $display("FAIL hold_after_done: got %h want 0000000f", {mr_out, acc_out}); end
  endtask

  task automatic test_priority();
    int dc, bc;
    do_op(MUL_GO | DIV_GO, 16'h0006, 16'h0007, dc, bc);
    checks++; if (dc != 17) begin errors++; $display("FAIL prio_done_cycle: got %0d want 17", dc); end
    checks++; if ({mr_out, acc_out} !== 32'h0000_002A) begin errors++; $display("FAIL prio_mul_wins: got %h want 0000002a", {mr_out, acc_out}); end
  endtask

`ifdef MUL_DIV_UNIT_DIV_EN
  task automatic test_div();
    logic [15:0] ta [3];
    logic [15:0] tb_ [3];
    logic [31:0] tr [3];
    int dc, bc;
    ta  = '{16'd100, 16'hFFF9, 16'h8000};
    tb_ = '{16'd7,   16'h0002, 16'hFFFF};
    tr  = '{32'h0002_000E, 32'hFFFF_FFFD, 32'h0000_8000};
    for (int i = 0; i < 3; i++) begin
      do_op(DIV_GO, ta[i], tb_[i], dc, bc);
      checks++; if (dc != 17) begin errors++; $display("FAIL div%0d_done_cycle: got %0d want 17", i, dc); end
      checks++; if (bc != 16) begin errors++; $display("FAIL div%0d_busy_cycles: got %0d want 16", i, bc); end
      checks++; if ({mr_out, acc_out} !== tr[i]) begin errors++; $display("FAIL div%0d_rem_quo: got %h want %h", i, {mr_out, acc_out}, tr[i]); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div%0d_dbz: got %b want 0", i, div_by_zero); end
    end
    do_op(DIV_GO, 16'h1234, 16'h0000, dc, bc);
    checks++; if (dc != 1) begin errors++; $display("FAIL dz_done_cycle: got %0d want 1", dc); end
    checks++; if (bc != 0) begin errors++; $display("FAIL dz_busy: got %0d want 0", bc); end
    checks++; if ({mr_out, acc_out} !== 32'h1234_FFFF) begin errors++; $display("FAIL dz_outputs: got %h want 1234ffff", {mr_out, acc_out}); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
    @(negedge clk);
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_sticky: got %b want 1", div_by_zero); end
    do_op(MUL_GO, 16'h0003, 16'h0005, dc, bc);
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_cleared: got %b want 0", div_by_zero); end
    checks++; if ({mr_out, acc_out} !== 32'h0000_000F) begin errors++; $display("FAIL dz_next_mul: got %h want 0000000f", {mr_out, acc_out}); end
  endtask
`else
  task automatic test_div_disabled();
    int dc, bc;
    int nbusy = 0;
    int ndone = 0;
    do_op(MUL_GO, 16'h0003, 16'h0005, dc, bc);
    @(negedge clk);
    control_signal = DIV_GO; acc_in = 16'd100; br_in = 16'd7;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      control_signal = 32'h0;
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) ndone++;
    end
    checks++; if (nbusy != 0) begin errors++; $display("FAIL nodiv_busy: got %0d want 0", nbusy); end
    checks++; if (ndone != 0) begin errors++; $display("FAIL nodiv_done: got %0d want 0", ndone); end
    checks++; if ({mr_out, acc_out} !== 32'h0000_000F) begin errors++; $display("FAIL nodiv_outputs: got %h want 0000000f", {mr_out, acc_out}); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL nodiv_dbz: got %b want 0", div_by_zero); end
  endtask
`endif

  task automatic test_reset_abort();
    int dc, bc;
    int saw_done = 0;
    @(negedge clk);
    control_signal = MUL_GO; acc_in = 16'h1234; br_in = 16'h0011;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done++;
      if (k == 7) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end
      end
      control_signal = (k == 5) ? DIV_GO : 32'h0;
      if (k == 8) rst = 1'b0;
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    checks++; if ({mr_out, acc_out} !== 32'h0) begin errors++; $display("FAIL abort_outputs: got %h want 00000000", {mr_out, acc_out}); end
    control_signal = MUL_GO; acc_in = 16'h0002; br_in = 16'h0002;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_over_start: got %b want 0", busy); end
    control_signal = 32'h0; rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done++;
    end
    checks++; if (saw_done != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", saw_done); end
    do_op(MUL_GO, 16'h0002, 16'h0002, dc, bc);
    checks++; if (dc != 17) begin errors++; $display("FAIL post_reset_done_cycle: got %0d want 17", dc); end
    checks++; if ({mr_out, acc_out} !== 32'h0000_0004) begin errors++; $display("FAIL post_reset_mul: got %h want 00000004", {mr_out, acc_out}); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_back_to_back();
    test_priority();
`ifdef MUL_DIV_UNIT_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
